updown_counter_param: RTL



---
 rtl/updown_counter_param.sv | 106 ++++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with per-cycle saturate/wrap selection, boundary
// flags and registered overflow/underflow pulses.
module updown_counter_param #(
    parameter int WIDTH     = 5,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = MIN_VAL,
    parameter int STEP_W    = WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              wrap,
    output logic [WIDTH-1:0]  out,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf,
    output logic              unf
);

    localparam int RANGE = MAX_VAL - MIN_VAL + 1;
    // One guard bit is enough: out + RANGE never reaches 2**(WIDTH+1).
    localparam int AW = WIDTH + 1;
    localparam int SW = (STEP_W > AW) ? STEP_W : AW;

    localparam logic [AW-1:0]    MIN_A   = AW'(MIN_VAL);
    localparam logic [AW-1:0]    MAX_A   = AW'(MAX_VAL);
    localparam logic [AW-1:0]    RANGE_A = AW'(RANGE);
    localparam logic [SW-1:0]    RANGE_S = SW'(RANGE);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] out_reg, out_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    logic [SW-1:0] step_ext;
    logic [AW-1:0] eff_step;
    logic [AW-1:0] cur;
    logic [AW-1:0] sum;
    logic [AW-1:0] load_ext;

    assign step_ext = SW'(step);
    assign eff_step = (step_ext > RANGE_S) ? RANGE_A : AW'(step_ext);
    assign cur      = {1'b0, out_reg};
    assign sum      = cur + eff_step;
    assign load_ext = {1'b0, load_val};

    always_comb begin
        out_next = out_reg;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (clear) begin
            out_next = RST_W;
        end else if (load) begin
            if (load_ext < MIN_A)
                out_next = MIN_W;
            else if (load_ext > MAX_A)
                out_next = MAX_W;
            else
                out_next = load_val;
        end else if ((inc != dec) && (eff_step != '0)) begin
            if (inc) begin
                if (sum > MAX_A) begin
                    ovf_next = 1'b1;
                    out_next = wrap ? WIDTH'(sum - RANGE_A) : MAX_W;
                end else begin
                    out_next = WIDTH'(sum);
                end
            end else begin
                // Compare against MIN+s so the subtraction never goes negative.
                if (cur >= MIN_A + eff_step) begin
                    out_next = WIDTH'(cur - eff_step);
                end else begin
                    unf_next = 1'b1;
                    out_next = wrap ? WIDTH'(cur + RANGE_A - eff_step) : MIN_W;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg <= RST_W;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    assign out    = out_reg;
    assign ovf    = ovf_reg;
    assign unf    = unf_reg;
    assign at_max = (out_reg == MAX_W);
    assign at_min = (out_reg == MIN_W);

endmodule
